// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported unified memory between instruction fetch (IF) and load/store (MEM).
// Each access runs IDLE -> BUSY (MEM_LAT cycles) -> RESP (one-cycle ready pulse) -> IDLE.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              flush_if,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam int CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STREAK_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {OWN_IF, OWN_MEM} owner_t;

    state_t              state, state_nxt;
    owner_t              owner;
    logic                we_q;
    logic                flush_q;
    logic [CNT_W-1:0]    cnt;
    logic [STREAK_W-1:0] streak;
    logic                grant_if, grant_mem;
    logic                starved;
    logic                if_drop;

    // IF wins a tie only once MEM has been granted STARVE_MAX times in a row while IF waited.
    assign starved = (streak == STREAK_W'(STARVE_MAX));

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        if (state == IDLE) begin
            if (dm_req && !(if_req && starved)) begin
                grant_mem = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    // A redirected fetch still completes on the memory but its response is dropped.
    assign if_drop = (owner == OWN_IF) && (flush_q || flush_if);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant_if || grant_mem) state_nxt = BUSY;
            BUSY:    if (cnt == '0) state_nxt = if_drop ? IDLE : RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        // NOTE: clocked state is written with <= so every register samples pre-edge values.
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        // NOTE: the read-data registers are plain flops, so they are reset along with the control state.
        if (!reset) begin
            owner     <= OWN_IF;
            we_q      <= 1'b0;
            flush_q   <= 1'b0;
            cnt       <= '0;
            streak    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            if (grant_mem) begin
                owner     <= OWN_MEM;
                we_q      <= dm_we;
                flush_q   <= 1'b0;
                cnt       <= CNT_W'(MEM_LAT - 1);
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
                if (!if_req) begin
                    streak <= '0;
                end else if (!starved) begin
                    streak <= streak + 1'b1;
                end
            end else if (grant_if) begin
                owner    <= OWN_IF;
                we_q     <= 1'b0;
                flush_q  <= 1'b0;
                cnt      <= CNT_W'(MEM_LAT - 1);
                mem_addr <= if_addr;
                streak   <= '0;
            end

            if (state == BUSY) begin
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end
                if (owner == OWN_IF && flush_if) begin
                    flush_q <= 1'b1;
                end
                // mem_rdata is valid only in the last enabled cycle; stores leave dm_rdata alone.
                if (cnt == '0) begin
                    if (owner == OWN_MEM) begin
                        if (!we_q) dm_rdata <= mem_rdata;
                    end else if (!if_drop) begin
                        if_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

    assign mem_en    = (state == BUSY);
    assign mem_we    = mem_en && (owner == OWN_MEM) && we_q;
    assign if_ready  = (state == RESP) && (owner == OWN_IF) && !flush_if;
    assign dm_ready  = (state == RESP) && (owner == OWN_MEM);
    assign stall_if  = if_req && !if_ready;
    assign stall_mem = dm_req && !dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level model of the arbitration and timing rules.
module tb_mem_port_arbiter;

    localparam int MEM_LAT     = 2;
    localparam int STARVE_MAX  = 2;
    localparam int RAND_CYCLES = 400;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0, flush_if = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ready, dm_ready, mem_en, mem_we, stall_if, stall_mem;

    // Memory environment: preload port plus the DUT write port, both in one process.
    logic [31:0] mem_arr [0:255];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;
    logic [31:0] ref_mem [0:255];

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_dm_q = '0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (pl_en) mem_arr[pl_idx] <= pl_data;
        else if (mem_en && mem_we) mem_arr[mem_addr[9:2]] <= mem_wdata;
    end

    assign mem_rdata = mem_arr[mem_addr[9:2]];

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .flush_if(flush_if),
        .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        pl_en = 1'b1; pl_idx = idx; pl_data = data;
        ref_mem[idx] = data;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        if_req = 1'b1;
        #1;
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset mem_en got %b exp 0", mem_en); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset mem_we got %b exp 0", mem_we); end
        checks++; if (if_ready !== 1'b0 || dm_ready !== 1'b0) begin errors++; $display("FAIL reset ready got %b%b exp 00", if_ready, dm_ready); end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset mem_addr/wdata got %h/%h exp 0/0", mem_addr, mem_wdata); end
        checks++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin errors++; $display("FAIL reset rdata got %h/%h exp 0/0", if_rdata, dm_rdata); end
        checks++; if (stall_if !== 1'b1 || stall_mem !== 1'b0) begin errors++; $display("FAIL reset stall got %b%b exp 10", stall_if, stall_mem); end
        if_req = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_if_fetch();
        preload(8'h10, 32'h00500093);
        if_req = 1'b1; if_addr = 32'h40;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clock);
            checks++; if (mem_en !== (k == 1 || k == 2)) begin errors++; $display("FAIL if_fetch mem_en k=%0d got %b", k, mem_en); end
            checks++; if (if_ready !== (k == 3)) begin errors++; $display("FAIL if_fetch if_ready k=%0d got %b", k, if_ready); end
            checks++; if (stall_if !== (k <= 2)) begin errors++; $display("FAIL if_fetch stall_if k=%0d got %b", k, stall_if); end
            if (k == 1 || k == 2) begin
                checks++; if (mem_addr !== 32'h40 || mem_we !== 1'b0) begin errors++; $display("FAIL if_fetch mem_addr k=%0d got %h we %b exp 40 we 0", k, mem_addr, mem_we); end
            end
            if (k == 3) begin
                checks++; if (if_rdata !== 32'h00500093) begin errors++; $display("FAIL if_fetch if_rdata got %h exp 00500093", if_rdata); end
            end
            tick();
            if (k == 3) if_req = 1'b0;
        end
    endtask

    task automatic test_simultaneous();
        preload(8'h11, 32'h00A00113);
        preload(8'h40, 32'hDEADBEEF);
        if_req = 1'b1; if_addr = 32'h44;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clock);
            checks++; if (mem_en !== (k == 1 || k == 2 || k == 5 || k == 6)) begin errors++; $display("FAIL simul mem_en k=%0d got %b", k, mem_en); end
            checks++; if (dm_ready !== (k == 3) || if_ready !== (k == 7)) begin errors++; $display("FAIL simul ready k=%0d got dm %b if %b", k, dm_ready, if_ready); end
            checks++; if (stall_mem !== (k < 3) || stall_if !== (k < 7)) begin errors++; $display("FAIL simul stall k=%0d got mem %b if %b", k, stall_mem, stall_if); end
            if (k == 1) begin
                checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL simul mem_addr first got %h exp 100", mem_addr); end
            end
            if (k == 5) begin
                checks++; if (mem_addr !== 32'h44) begin errors++; $display("FAIL simul mem_addr second got %h exp 44", mem_addr); end
            end
            if (k == 3) begin
                checks++; if (dm_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL simul dm_rdata got %h exp deadbeef", dm_rdata); end
                exp_dm_q = 32'hDEADBEEF;
            end
            if (k == 7) begin
                checks++; if (if_rdata !== 32'h00A00113) begin errors++; $display("FAIL simul if_rdata got %h exp 00a00113", if_rdata); end
            end
            tick();
            if (k == 3) dm_req = 1'b0;
            if (k == 7) if_req = 1'b0;
        end
    endtask

    task automatic test_starvation();
        bit          own_if [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        int          ifn = 0, dmn = 0, g;
        logic [31:0] ea;
        if_req = 1'b1; if_addr = 32'h60;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
        for (int k = 0; k < 24; k++) begin
            g  = k / 4;
            ea = own_if[g] ? 32'h60 + 32'(4 * ifn) : 32'h80 + 32'(4 * dmn);
            @(negedge clock);
            checks++; if (mem_en !== (k % 4 == 1 || k % 4 == 2)) begin errors++; $display("FAIL starve mem_en k=%0d got %b", k, mem_en); end
            checks++; if (if_ready !== (k % 4 == 3 && own_if[g]) || dm_ready !== (k % 4 == 3 && !own_if[g])) begin
                errors++; $display("FAIL starve grant %0d ready got if %b dm %b exp owner_if %b", g, if_ready, dm_ready, own_if[g]);
            end
            if (k % 4 == 1) begin
                checks++; if (mem_addr !== ea) begin errors++; $display("FAIL starve mem_addr grant %0d got %h exp %h", g, mem_addr, ea); end
            end
            if (k % 4 == 3) begin
                if (own_if[g]) begin
                    checks++; if (if_rdata !== ref_mem[ea[9:2]]) begin errors++; $display("FAIL starve if_rdata got %h exp %h", if_rdata, ref_mem[ea[9:2]]); end
                end else begin
                    checks++; if (dm_rdata !== ref_mem[ea[9:2]]) begin errors++; $display("FAIL starve dm_rdata got %h exp %h", dm_rdata, ref_mem[ea[9:2]]); end
                    exp_dm_q = ref_mem[ea[9:2]];
                end
            end
            tick();
            if (k % 4 == 3) begin
                if (own_if[g]) begin ifn++; if_addr = 32'h60 + 32'(4 * ifn); end
                else begin dmn++; dm_addr = 32'h80 + 32'(4 * dmn); end
            end
        end
        if_req = 1'b0; dm_req = 1'b0;
        tick();
    endtask

    task automatic test_store();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'h12345678;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clock);
            checks++; if (mem_en !== (k == 1 || k == 2) || mem_we !== (k == 1 || k == 2)) begin errors++; $display("FAIL store en/we k=%0d got %b%b", k, mem_en, mem_we); end
            if (k == 1 || k == 2) begin
                checks++; if (mem_addr !== 32'h200 || mem_wdata !== 32'h12345678) begin errors++; $display("FAIL store bus k=%0d got %h/%h exp 200/12345678", k, mem_addr, mem_wdata); end
            end
            checks++; if (dm_ready !== (k == 3)) begin errors++; $display("FAIL store dm_ready k=%0d got %b", k, dm_ready); end
            if (k >= 3) begin
                checks++; if (dm_rdata !== exp_dm_q) begin errors++; $display("FAIL store dm_rdata k=%0d got %h exp %h", k, dm_rdata, exp_dm_q); end
            end
            tick();
            if (k == 3) begin dm_req = 1'b0; dm_we = 1'b0; end
        end
        ref_mem[8'h80] = 32'h12345678;
        checks++; if (mem_arr[8'h80] !== 32'h12345678) begin errors++; $display("FAIL store memory word got %h exp 12345678", mem_arr[8'h80]); end
    endtask

    task automatic test_flush();
        if_req = 1'b1; if_addr = 32'h48;
        for (int k = 0; k <= 7; k++) begin
            @(negedge clock);
            checks++; if (mem_en !== (k == 1 || k == 2 || k == 4 || k == 5)) begin errors++; $display("FAIL flush mem_en k=%0d got %b", k, mem_en); end
            checks++; if (if_ready !== (k == 6)) begin errors++; $display("FAIL flush if_ready k=%0d got %b", k, if_ready); end
            checks++; if (stall_if !== (k < 6)) begin errors++; $display("FAIL flush stall_if k=%0d got %b", k, stall_if); end
            if (k == 4) begin
                checks++; if (mem_addr !== 32'h4C) begin errors++; $display("FAIL flush regrant addr got %h exp 4c", mem_addr); end
            end
            if (k == 6) begin
                checks++; if (if_rdata !== ref_mem[8'h13]) begin errors++; $display("FAIL flush if_rdata got %h exp %h", if_rdata, ref_mem[8'h13]); end
            end
            tick();
            flush_if = (k == 0);
            if (k == 2) if_addr = 32'h4C;
            if (k == 6) if_req = 1'b0;
        end
    endtask

    task automatic test_reset_mid_busy();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h104;
        tick();
        checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL rst_busy pre mem_en got %b exp 1", mem_en); end
        #2 reset = 1'b0;
        #1;
        checks++; if (mem_en !== 1'b0 || dm_ready !== 1'b0) begin errors++; $display("FAIL rst_busy async clear got en %b ready %b exp 0 0", mem_en, dm_ready); end
        checks++; if (mem_addr !== 32'h0 || dm_rdata !== 32'h0 || if_rdata !== 32'h0) begin errors++; $display("FAIL rst_busy regs got %h %h %h exp 0", mem_addr, dm_rdata, if_rdata); end
        checks++; if (stall_mem !== 1'b1) begin errors++; $display("FAIL rst_busy stall_mem got %b exp 1", stall_mem); end
        exp_dm_q = '0;
        dm_req = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        tick();
        dm_req = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clock);
            checks++; if (mem_en !== (k == 1 || k == 2) || dm_ready !== (k == 3)) begin errors++; $display("FAIL rst_busy latency k=%0d got en %b ready %b", k, mem_en, dm_ready); end
            if (k == 3) begin
                checks++; if (dm_rdata !== ref_mem[8'h41]) begin errors++; $display("FAIL rst_busy dm_rdata got %h exp %h", dm_rdata, ref_mem[8'h41]); end
                exp_dm_q = ref_mem[8'h41];
            end
            tick();
            if (k == 3) dm_req = 1'b0;
        end
    endtask

    task automatic test_random();
        bit          act = 0, act_if = 0, act_we = 0, if_pend = 0, dm_pend = 0;
        bit          exp_en, exp_ifr, exp_dmr;
        int          g_c = 0, streak_m = 0, k;
        logic [31:0] act_addr = '0, act_data = '0;
        for (int c = 0; c < RAND_CYCLES; c++) begin
            if (act && c - g_c == MEM_LAT + 2) begin
                act = 0;
                if (act_if) if_pend = 0; else dm_pend = 0;
            end
            if (c < RAND_CYCLES - 20) begin
                if (!if_pend && $urandom_range(0, 2) != 0) begin
                    if_pend = 1; if_addr = 32'($urandom_range(0, 255)) << 2;
                end
                if (!dm_pend && $urandom_range(0, 2) != 0) begin
                    dm_pend = 1; dm_we = 1'($urandom_range(0, 1));
                    dm_addr = 32'($urandom_range(0, 255)) << 2; dm_wdata = $urandom;
                end
            end
            if_req = if_pend; dm_req = dm_pend;
            // Arbitration rule: MEM first unless IF has waited through STARVE_MAX MEM grants.
            if (!act && (if_pend || dm_pend)) begin
                act_if = if_pend && (!dm_pend || streak_m == STARVE_MAX);
                if (act_if || !if_pend) streak_m = 0;
                else if (streak_m < STARVE_MAX) streak_m++;
                act_addr = act_if ? if_addr : dm_addr;
                act_we   = !act_if && dm_we;
                if (act_we) ref_mem[dm_addr[9:2]] = dm_wdata;
                else act_data = ref_mem[act_addr[9:2]];
                act = 1; g_c = c;
            end
            @(negedge clock);
            k       = c - g_c;
            exp_en  = act && k >= 1 && k <= MEM_LAT;
            exp_ifr = act && act_if && k == MEM_LAT + 1;
            exp_dmr = act && !act_if && k == MEM_LAT + 1;
            checks++; if (mem_en !== exp_en || mem_we !== (exp_en && act_we)) begin errors++; $display("FAIL random en/we c=%0d got %b%b exp %b%b", c, mem_en, mem_we, exp_en, exp_en && act_we); end
            checks++; if (if_ready !== exp_ifr || dm_ready !== exp_dmr) begin errors++; $display("FAIL random ready c=%0d got if %b dm %b exp if %b dm %b", c, if_ready, dm_ready, exp_ifr, exp_dmr); end
            checks++; if (stall_if !== (if_pend && !exp_ifr) || stall_mem !== (dm_pend && !exp_dmr)) begin errors++; $display("FAIL random stall c=%0d got %b%b", c, stall_if, stall_mem); end
            if (exp_en) begin
                checks++; if (mem_addr !== act_addr) begin errors++; $display("FAIL random mem_addr c=%0d got %h exp %h", c, mem_addr, act_addr); end
            end
            if (exp_ifr) begin
                checks++; if (if_rdata !== act_data) begin errors++; $display("FAIL random if_rdata c=%0d got %h exp %h", c, if_rdata, act_data); end
            end
            if (exp_dmr) begin
                if (!act_we) exp_dm_q = act_data;
                checks++; if (dm_rdata !== exp_dm_q) begin errors++; $display("FAIL random dm_rdata c=%0d got %h exp %h", c, dm_rdata, exp_dm_q); end
            end
            tick();
        end
        if_req = 1'b0; dm_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) preload(8'(i), $urandom);
        test_reset();
        test_if_fetch();
        test_simultaneous();
        test_starvation();
        test_store();
        test_flush();
        test_reset_mid_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
